// File: rtl/fft_frame_packer_if.sv
// AXI-Stream link carrying packed complex samples from the frame packer
// to the FFT core. The packer drives through the master modport.
interface fft_frame_packer_if;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: collects windowed 8-bit samples into ping-pong frame
// banks of FRAME_LEN entries and streams complete frames to an FFT core as
// {8'h00 imaginary, real} AXI-Stream beats, with tlast on the last beat.
// Optional feature macro: FRAME_PACKER_FRAME_COUNT_EN adds frame_count_out,
// a 16-bit wrapping count of frames fully handed to the FFT core.
module fft_frame_packer #(
  parameter int FRAME_LEN = 1024
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [7:0]         in_sample,
  input  logic               sample_valid_in,
  fft_frame_packer_if.master m_axis,
  output logic               overrun_out
`ifdef FRAME_PACKER_FRAME_COUNT_EN
  ,
  output logic [15:0]        frame_count_out
`endif
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  // Both banks share one RAM; the bank number is the top address bit.
  logic [7:0]    mem [0:2*FRAME_LEN-1];

  bank_state_t   bank_state [2];
  logic [AW-1:0] wr_idx_reg;
  logic [AW-1:0] rd_idx_reg;
  logic          rd_bank_reg;
  logic          rd_pending_reg;
  logic          newest_full_reg;
  logic [15:0]   tdata_reg;
  logic          tvalid_reg;
  logic          tlast_reg;
  logic          overrun_reg;

  logic          xfer;
  logic          drain_done;
  logic [1:0]    is_full;
  logic [1:0]    is_filling;
  logic [1:0]    is_draining;
  logic [1:0]    is_free;

  assign xfer       = tvalid_reg && m_axis.m_axis_tready;
  assign drain_done = xfer && tlast_reg;

  // Per-bank status. A bank whose final beat is being accepted this cycle
  // counts as free: that beat already sits in the output register, so the
  // bank's storage can take new samples on the same edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign is_full[gi]     = (bank_state[gi] == FULL);
      assign is_filling[gi]  = (bank_state[gi] == FILLING);
      assign is_draining[gi] = (bank_state[gi] == DRAINING);
      assign is_free[gi]     = (bank_state[gi] == EMPTY) ||
                               (drain_done && (rd_bank_reg == 1'(gi)) && is_draining[gi]);
    end
  endgenerate

  logic          filling_any;
  logic          free_any;
  logic          claim;
  logic          claim_bank;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_slot;
  logic          fill_done;
  logic          handoff;
  logic          start;
  logic          start_bank;
  logic          load_next;
  logic          rd_load;
  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_addr;

  // Writer/reader decisions for the coming edge.
  always_comb begin
    filling_any = |is_filling;
    free_any    = |is_free;
    // With nothing filling, a free bank is claimed at once; a sample that
    // arrives in that cycle lands in its slot 0.
    claim       = !filling_any && free_any;
    claim_bank  = !is_free[0];
    wr_en       = sample_valid_in && (filling_any || claim);
    wr_bank     = filling_any ? is_filling[1] : claim_bank;
    wr_slot     = filling_any ? wr_idx_reg : '0;
    fill_done   = wr_en && (wr_slot == LAST_IDX);
    handoff     = fill_done && is_free[~wr_bank];
    // A new drain may start when idle or on the very edge the previous
    // frame's tlast is accepted, so back-to-back frames have no gap.
    start       = (!(|is_draining) || drain_done) && (|is_full);
    start_bank  = (&is_full) ? ~newest_full_reg : is_full[1];
    load_next   = (|is_draining) && rd_pending_reg && (!tvalid_reg || m_axis.m_axis_tready);
    rd_load     = start || load_next;
    rd_addr     = start ? {start_bank, {AW{1'b0}}} : {rd_bank_reg, rd_idx_reg};
    wr_addr     = {wr_bank, wr_slot};
  end

  // Sample RAM write port.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= in_sample;
    end
  end

  // Synchronous RAM read straight into the output data register; it only
  // advances when the current beat is absent or being accepted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tdata_reg <= '0;
    end else if (rd_load) begin
      tdata_reg <= {8'h00, mem[rd_addr]};
    end
  end

  // Bank state machine, write index, drain sequencing and status outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bank_state[0]   <= FILLING;
      bank_state[1]   <= EMPTY;
      wr_idx_reg      <= '0;
      rd_idx_reg      <= '0;
      rd_bank_reg     <= 1'b0;
      rd_pending_reg  <= 1'b0;
      newest_full_reg <= 1'b0;
      tvalid_reg      <= 1'b0;
      tlast_reg       <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      overrun_reg <= sample_valid_in && !wr_en;

      if (wr_en) begin
        wr_idx_reg <= fill_done ? '0 : wr_slot + 1'b1;
      end
      if (fill_done) begin
        newest_full_reg <= wr_bank;
      end

      // Later assignments take priority; the cases touch distinct banks
      // except drain completion followed by a refill claim.
      for (int b = 0; b < 2; b++) begin
        if (drain_done && (rd_bank_reg == 1'(b))) begin
          bank_state[b] <= EMPTY;
        end
        if (start && (start_bank == 1'(b))) begin
          bank_state[b] <= DRAINING;
        end
        if ((claim && (claim_bank == 1'(b))) || (handoff && (wr_bank != 1'(b)))) begin
          bank_state[b] <= FILLING;
        end
        if (fill_done && (wr_bank == 1'(b))) begin
          bank_state[b] <= FULL;
        end
      end

      if (start) begin
        rd_bank_reg    <= start_bank;
        rd_idx_reg     <= AW'(1);
        rd_pending_reg <= 1'b1;
        tvalid_reg     <= 1'b1;
        tlast_reg      <= 1'b0;
      end else if (load_next) begin
        rd_idx_reg     <= rd_idx_reg + 1'b1;
        rd_pending_reg <= (rd_idx_reg != LAST_IDX);
        tvalid_reg     <= 1'b1;
        tlast_reg      <= (rd_idx_reg == LAST_IDX);
      end else if (xfer) begin
        tvalid_reg     <= 1'b0;
        tlast_reg      <= 1'b0;
      end
    end
  end

  assign m_axis.m_axis_tdata  = tdata_reg;
  assign m_axis.m_axis_tvalid = tvalid_reg;
  assign m_axis.m_axis_tlast  = tlast_reg;
  assign overrun_out          = overrun_reg;

`ifdef FRAME_PACKER_FRAME_COUNT_EN
  logic [15:0] frame_count_reg;

  // Count frames whose tlast beat has been accepted; wraps naturally.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_count_reg <= '0;
    end else if (drain_done) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count_out = frame_count_reg;
`endif

endmodule

// File: tb/tb_fft_frame_packer.sv
// Testbench for fft_frame_packer (FRAME_LEN=16): table-driven scenarios,
// hand-written reset/frame-count sequences and randomized traffic, all
// checked against a frame-level reference model (queues of samples/beats).
module tb_fft_frame_packer;
  localparam int FL = 16;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [7:0]  in_sample;
  logic        sample_valid_in;
  logic        overrun_out;
`ifdef FRAME_PACKER_FRAME_COUNT_EN
  logic [15:0] frame_count_out;
`endif

  fft_frame_packer_if axis ();

  always #5 clk = ~clk;

  fft_frame_packer #(.FRAME_LEN(FL)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .in_sample       (in_sample),
    .sample_valid_in (sample_valid_in),
    .m_axis          (axis),
    .overrun_out     (overrun_out)
`ifdef FRAME_PACKER_FRAME_COUNT_EN
    ,
    .frame_count_out (frame_count_out)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int         n_samples;
    int         period;
    int         mode;       // 0 ready, 1 toggle, 2 held off while feeding, 3 random
    logic [7:0] base;
    int         exp_beats;
    int         exp_lasts;
    int         exp_ovr;
  } vec_t;

  // Reference model: partial frame being collected, complete frames waiting
  // for (or in) transfer, and how many banks those complete frames occupy.
  beat_t       exp_q[$];
  logic [7:0]  partial_q[$];
  int          outstanding;
  int          frames_done;
  logic        exp_ovr;

  logic        prev_stall;
  logic [15:0] prev_tdata;
  logic        prev_tlast;
  logic        tog;

  int sc_beats, sc_lasts, sc_ovr, gap_run, max_gap;
  int checks, errors;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic get_ready(input int mode, input bit feeding, output logic r);
    case (mode)
      1:       begin tog = ~tog; r = tog; end
      2:       r = feeding ? 1'b0 : 1'b1;
      3:       r = 1'($urandom_range(0, 1));
      default: r = 1'b1;
    endcase
  endtask

  // One clock cycle: check what the previous edge produced, drive the next
  // inputs, then advance the model over the coming edge.
  task automatic step(input logic v, input logic [7:0] s, input logic r);
    beat_t b;
    @(negedge clk);
    chk("overrun", overrun_out, exp_ovr);
    if (overrun_out) sc_ovr++;
    if (prev_stall) begin
      chk("stall_tvalid", axis.m_axis_tvalid, 1);
      chk("stall_tdata", axis.m_axis_tdata, prev_tdata);
      chk("stall_tlast", axis.m_axis_tlast, prev_tlast);
    end
    sample_valid_in    = v;
    in_sample          = s;
    axis.m_axis_tready = r;

    if (r && exp_q.size() > 0 && !axis.m_axis_tvalid) gap_run++;
    else gap_run = 0;
    if (gap_run > max_gap) max_gap = gap_run;

    if (axis.m_axis_tvalid && r) begin
      sc_beats++;
      if (axis.m_axis_tlast) sc_lasts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected no beat", axis.m_axis_tdata);
      end else begin
        b = exp_q.pop_front();
        chk("tdata", axis.m_axis_tdata, b.data);
        chk("tlast", axis.m_axis_tlast, b.last);
        if (b.last) begin
          outstanding--;
          frames_done++;
        end
      end
    end

    exp_ovr = 1'b0;
    if (v) begin
      if (partial_q.size() > 0 || outstanding < 2) begin
        partial_q.push_back(s);
        if (partial_q.size() == FL) begin
          for (int i = 0; i < FL; i++) begin
            b.data = {8'h00, partial_q[i]};
            b.last = (i == FL - 1);
            exp_q.push_back(b);
          end
          partial_q.delete();
          outstanding++;
        end
      end else begin
        exp_ovr = 1'b1;
      end
    end

    prev_stall = axis.m_axis_tvalid && !r;
    prev_tdata = axis.m_axis_tdata;
    prev_tlast = axis.m_axis_tlast;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("overrun", overrun_out, exp_ovr);
    rst_in             = 1'b1;
    sample_valid_in    = 1'b0;
    in_sample          = 8'h00;
    axis.m_axis_tready = 1'b0;
    @(negedge clk);
    rst_in = 1'b0;
    chk("rst_tvalid", axis.m_axis_tvalid, 0);
    chk("rst_tlast", axis.m_axis_tlast, 0);
    chk("rst_tdata", axis.m_axis_tdata, 0);
    chk("rst_overrun", overrun_out, 0);
`ifdef FRAME_PACKER_FRAME_COUNT_EN
    chk("rst_frame_count", frame_count_out, 0);
`endif
    exp_q.delete();
    partial_q.delete();
    outstanding = 0;
    frames_done = 0;
    exp_ovr     = 1'b0;
    prev_stall  = 1'b0;
    sc_beats    = 0;
    sc_lasts    = 0;
    sc_ovr      = 0;
    gap_run     = 0;
    max_gap     = 0;
  endtask

  // Keep stepping with no input until every modelled beat has gone out.
  task automatic drain(input int mode);
    logic r;
    int   n;
    n = 0;
    while ((exp_q.size() > 0 || axis.m_axis_tvalid) && n < 400) begin
      get_ready(mode, 1'b0, r);
      step(1'b0, 8'h00, r);
      n++;
    end
    step(1'b0, 8'h00, 1'b1);
    chk("drained_queue", exp_q.size(), 0);
    chk("drained_tvalid", axis.m_axis_tvalid, 0);
`ifdef FRAME_PACKER_FRAME_COUNT_EN
    chk("frame_count", frame_count_out, frames_done);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[4];
    logic       r;
    logic [7:0] s;
    int         n;

    vecs[0] = '{16, 4, 0, 8'hF8, 16, 1, 0};   // steady ready, -8..7
    vecs[1] = '{16, 4, 1, 8'hF8, 16, 1, 0};   // tready toggling
    vecs[2] = '{40, 1, 2, 8'h10, 32, 2, 8};   // two frames buffered, 8 dropped
    vecs[3] = '{64, 1, 0, 8'h40, 64, 4, 0};   // continuous input, back-to-back

    checks = 0;
    errors = 0;
    tog = 1'b0;
    exp_ovr = 1'b0;
    prev_stall = 1'b0;
    rst_in = 1'b1;
    sample_valid_in = 1'b0;
    in_sample = 8'h00;
    axis.m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int k = 0; k < 4; k++) begin
      do_reset();
      for (int i = 0; i < vecs[k].n_samples; i++) begin
        s = vecs[k].base + 8'(i);
        get_ready(vecs[k].mode, 1'b1, r);
        step(1'b1, s, r);
        for (int p = 1; p < vecs[k].period; p++) begin
          get_ready(vecs[k].mode, 1'b1, r);
          step(1'b0, 8'h00, r);
        end
      end
      drain(vecs[k].mode);
      chk("vec_beats", sc_beats, vecs[k].exp_beats);
      chk("vec_lasts", sc_lasts, vecs[k].exp_lasts);
      chk("vec_overruns", sc_ovr, vecs[k].exp_ovr);
      chk("vec_gap_le3", (max_gap <= 3) ? 1 : 0, 1);
    end

    // Reset after 10 beats of a frame, then a clean new frame.
    do_reset();
    for (int i = 0; i < FL; i++) step(1'b1, 8'h80 + 8'(i), 1'b1);
    n = 0;
    while (sc_beats < 10 && n < 100) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("beats_before_reset", sc_beats, 10);
    do_reset();
    for (int i = 0; i < FL; i++) step(1'b1, 8'(i * 3), 1'b1);
    drain(0);
    chk("post_reset_beats", sc_beats, FL);
    chk("post_reset_lasts", sc_lasts, 1);

`ifdef FRAME_PACKER_FRAME_COUNT_EN
    // Three complete frames with sparse input.
    do_reset();
    for (int i = 0; i < 3 * FL; i++) begin
      step(1'b1, 8'(i), 1'b1);
      step(1'b0, 8'h00, 1'b1);
    end
    drain(0);
    chk("frame_count_3", frame_count_out, 3);
    do_reset();
`endif

    // Randomized traffic at several input densities and random backpressure.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(0, 99) < (30 + 35 * round)) ? 1'b1 : 1'b0,
             8'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end
      drain(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_packer.md
FFT_FRAME_PACKER -- requirements
Module: fft_frame_packer

Interface
REQ-001 Parameter: FRAME_LEN, default 1024, samples per FFT frame (power of two, 16..4096).
REQ-002 Port: clk_in  input  1  system clock (100 MHz); all logic on rising edge.
REQ-003 Port: rst_in  input  1  synchronous, active-high reset.
REQ-004 Port: in_sample  input  8  signed windowed sample from hanning_window.
REQ-005 Port: sample_valid_in  input  1  single-cycle strobe qualifying in_sample.
REQ-006 Port: m_axis_tdata  output  16  {8'h00 imaginary, real sample[7:0]} to FFT core.
REQ-007 Port: m_axis_tvalid  output  1  AXI-Stream valid.
REQ-008 Port: m_axis_tready  input  1  AXI-Stream ready from FFT core.
REQ-009 Port: m_axis_tlast  output  1  high on the FRAME_LEN-th beat of each frame.
REQ-010 Port: overrun_out  output  1  one-cycle pulse per dropped input sample.

Function
REQ-011 Storage: two banks (ping-pong) of FRAME_LEN x 8 bits; inferable as block RAM with one-cycle synchronous read.
REQ-012 Each bank has state EMPTY, FILLING, FULL, or DRAINING; after reset bank 0 is FILLING and bank 1 is EMPTY.
REQ-013 Writer: on sample_valid_in, the sample is written to the FILLING bank at write index; the index increments by 1.
REQ-014 Writer: the write at index FRAME_LEN-1 marks the bank FULL, resets the index to 0, and makes the other bank FILLING if it is EMPTY.
REQ-015 Writer: if no bank is FILLING when sample_valid_in arrives, the sample is discarded and overrun_out pulses the next cycle; the write index stays at 0.
REQ-016 Writer: a bank freed by the reader becomes FILLING on the cycle after it becomes EMPTY, if no bank is FILLING.
REQ-017 Reader: when a bank is FULL and no bank is DRAINING, that bank becomes DRAINING; if both banks are FULL, the older one is taken first.
REQ-018 Reader: m_axis_tvalid asserts no later than 3 cycles after the bank becomes DRAINING.
REQ-019 Reader: beats are emitted in write order, index 0 through FRAME_LEN-1.
REQ-020 Reader: a beat transfers when m_axis_tvalid && m_axis_tready.
REQ-021 Reader: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast hold stable; m_axis_tvalid never deasserts before the transfer.
REQ-022 Reader: under continuous m_axis_tready, one beat transfers per cycle with no bubbles inside a frame.
REQ-023 Reader: the transfer with tlast returns the bank to EMPTY; the next FULL bank may start on the following cycle.
REQ-024 Simultaneous events: a sample write and a read beat in the same cycle are both honoured; the writer never writes a DRAINING bank.
REQ-025 Simultaneous events: a write completion and a drain completion in the same cycle resolve without losing either the frame or the sample.
REQ-026 m_axis_tdata[15:8] is always 8'h00; m_axis_tdata[7:0] equals the stored sample bit-exact, with no scaling.

Reset
REQ-027 rst_in has priority over all other inputs and takes effect at the next clock edge.
REQ-028 At reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overrun_out=0; indices zeroed; banks set per REQ-012.
REQ-029 Reset mid-frame discards all partial and full frames, and the interrupted stream is not completed; RAM contents need not be cleared.

Configuration
REQ-030 Macro FRAME_PACKER_FRAME_COUNT_EN defined: adds output frame_count_out (16 bits), reset to 0, which increments by 1 on each tlast transfer and wraps from 65535 to 0.
REQ-031 Macro FRAME_PACKER_FRAME_COUNT_EN undefined: the frame_count_out port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 FRAME_LEN=16, samples -8..7 every 4 cycles, tready=1 -> 16 beats with tdata 16'h00F8..16'h0007, tlast on beat 16 only, overrun_out never high.
REQ-033 Same stimulus, tready toggling 1/0 each cycle -> identical beat sequence; tdata and tlast stable during every stall.
REQ-034 FRAME_LEN=16, tready=0, 40 samples -> frames 1-2 are buffered and samples 33-40 each pulse overrun_out; then tready=1 -> exactly 32 beats in order, 2 tlasts.
REQ-035 Assert rst_in after 10 beats of a frame -> tvalid=0 next cycle; a new 16-sample frame then emits cleanly with index 0 first.
REQ-036 With FRAME_PACKER_FRAME_COUNT_EN, 3 complete frames -> frame_count_out=3; rst_in -> 0.
REQ-037 Continuous 1-sample-per-cycle input with tready=1 -> no overrun and back-to-back frames with no inter-frame gap beyond 3 cycles.
